// File: rtl/ysyx_pipe_stage_pkg.sv
// Shared definitions for the generic pipeline register: occupancy encodings,
// per-stage payload layouts, their widths and the bubble values they carry.
package ysyx_pipe_stage_pkg;

    localparam int OCC_WIDTH = 2;

    typedef enum logic [OCC_WIDTH-1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] rs1_val;
        logic [63:0] rs2_val;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic        rd_wen;
    } id_ex_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] alu_res;
        logic [63:0] store_val;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        mem_ren;
        logic        mem_wen;
    } ex_mem_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] wb_val;
        logic [4:0]  rd;
        logic        rd_wen;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    // Bubbles carry a NOP in the instruction field and never write a register.
    localparam if_id_t IF_ID_BUBBLE = '{
        pc: 64'h0, instr: NOP_INSTR
    };
    localparam id_ex_t ID_EX_BUBBLE = '{
        pc: 64'h0, instr: NOP_INSTR, rs1_val: 64'h0, rs2_val: 64'h0,
        imm: 64'h0, rd: 5'd0, rd_wen: 1'b0
    };
    localparam ex_mem_t EX_MEM_BUBBLE = '{
        pc: 64'h0, instr: NOP_INSTR, alu_res: 64'h0, store_val: 64'h0,
        rd: 5'd0, rd_wen: 1'b0, mem_ren: 1'b0, mem_wen: 1'b0
    };
    localparam mem_wb_t MEM_WB_BUBBLE = '{
        pc: 64'h0, instr: NOP_INSTR, wb_val: 64'h0, rd: 5'd0, rd_wen: 1'b0
    };

endpackage

// File: rtl/ysyx_sat_counter.sv
// Saturating event counter with synchronous clear; shared by the performance
// statistics of the pipeline.
module ysyx_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ysyx_pipe_stage.sv
// Parametrised valid/ready pipeline register with optional 2-entry skid
// buffer, synchronous flush with bubble insertion and a stall counter.
module ysyx_pipe_stage
    import ysyx_pipe_stage_pkg::*;
#(
    parameter int                DATA_W = 128,
    parameter int                SKID   = 1,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
    parameter int                CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [OCC_WIDTH-1:0] occupancy,
    input  logic                 stat_clr_i,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic accept;
    logic pop;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    if (SKID == 0) begin : g_single

        logic              valid_q;
        logic [DATA_W-1:0] data_q;

        assign in_ready  = ~rst & (~valid_q | out_ready);
        assign out_valid = valid_q;
        assign out_data  = data_q;
        assign occupancy = {1'b0, valid_q};

        // NOTE: the payload register is reset too, so out_data is a defined
        // BUBBLE from the first cycle and no X leaks into the next stage.
        always_ff @(posedge clk) begin
            if (rst || flush_i) begin
                valid_q <= 1'b0;
                data_q  <= BUBBLE;
            end else if (accept) begin
                valid_q <= 1'b1;
                data_q  <= in_data;
            end else if (pop) begin
                valid_q <= 1'b0;
                data_q  <= BUBBLE;
            end
        end

    end else begin : g_skid

        occ_e              state_q, state_d;
        logic [DATA_W-1:0] main_q, main_d;
        logic [DATA_W-1:0] skid_q, skid_d;
        logic              ready_q;

        // Registered ready; rst only masks it so nothing is taken during reset.
        assign in_ready  = ready_q & ~rst;
        assign out_valid = (state_q != OCC_EMPTY);
        assign out_data  = main_q;
        assign occupancy = state_q;

        // NOTE: every output of this block is given a default first, so no
        // path through the case statement can infer a latch.
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            unique case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        state_d = OCC_ONE;
                        main_d  = in_data;
                    end
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = OCC_TWO;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = OCC_EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        state_d = OCC_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = OCC_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
            if (flush_i) begin
                state_d = OCC_EMPTY;
                main_d  = BUBBLE;
                skid_d  = BUBBLE;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= OCC_EMPTY;
                main_q  <= BUBBLE;
                skid_q  <= BUBBLE;
                ready_q <= 1'b1;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
                ready_q <= (state_d != OCC_TWO);
            end
        end

    end

    ysyx_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (stat_clr_i),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: doc/ysyx_pipe_stage.md
Name: ysyx_pipe_stage

Overview:
- Generic, parametrised pipeline register used between adjacent stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces the fixed-field, always-advancing stage buffers.
- Adds a valid/ready handshake, an optional 2-entry skid buffer that gives a registered in_ready at full throughput, and synchronous flush with bubble insertion.
- Adds a saturating back-pressure (stall) counter for performance analysis.
- Payload is an opaque DATA_W-bit bundle that the instantiating stage packs and unpacks.

Parameters:
- DATA_W, 128, payload width in bits (>=1).
- SKID, 1, 0 = single register with combinational in_ready; 1 = 2-entry skid buffer with registered in_ready.
- BUBBLE, {DATA_W{1'b0}}, payload value presented whenever out_valid=0, e.g. NOP-encoded fields.
- CNT_W, 32, stall counter width (>=1).

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- flush_i, in, 1, discard all held entries this cycle.
- in_valid, in, 1, upstream payload valid.
- in_ready, out, 1, stage can accept this cycle.
- in_data, in, DATA_W, upstream payload.
- out_valid, out, 1, payload valid to downstream.
- out_ready, in, 1, downstream accepts this cycle.
- out_data, out, DATA_W, payload to downstream.
- occupancy, out, 2, entries currently held (0..2; max 1 when SKID=0).
- stat_clr_i, in, 1, clear stall counter.
- stall_cnt, out, CNT_W, cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshake definitions:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Payload order is strictly FIFO. No payload is lost or duplicated except by flush.
- Reset (rst=1 on a clock edge): out_valid=0, out_data=BUBBLE, occupancy=0, stall_cnt=0.
  - While rst=1, in_ready=0 in both modes.
  - A transfer attempted while rst=1 is not accepted.
  - Reset asserted mid-operation drops all entries; rst has priority over every other input.
- Invariant: out_data==BUBBLE whenever out_valid=0. A pop with no refill reloads the output register with BUBBLE.
- SKID=0 mode:
  - in_ready = ~out_valid | out_ready (combinational from out_ready).
  - Latency: in_data is visible on out_data one cycle after accept.
  - accept & pop in the same cycle: the register takes the new data and out_valid stays 1 (full throughput).
- SKID=1 mode, state = occupancy:
  - EMPTY(0):
    - accept -> ONE, main <= in_data.
  - ONE(1):
    - accept & pop -> ONE, main <= in_data.
    - accept & ~pop -> TWO, skid <= in_data.
    - pop & ~accept -> EMPTY.
  - TWO(2):
    - in_ready=0, so no accept is possible.
    - pop -> ONE, main <= skid, skid cleared to BUBBLE.
  - out_data = main register; out_valid = (state != EMPTY).
  - in_ready is a flop equal to (next_state != TWO); it has no combinational path from out_ready.
  - Latency is 1 cycle when EMPTY. Sustained throughput is 1 transfer/cycle with out_ready=1.
- Flush (flush_i=1, rst=0):
  - Next cycle: occupancy=0, out_valid=0, out_data=BUBBLE; SKID=1 in_ready=1.
  - A pop in the same cycle completes normally downstream.
  - An accept in the same cycle completes from the upstream view, but the payload is discarded.
  - Flush does not affect stall_cnt.
- Stall counter:
  - Increments by 1 on each cycle with out_valid & ~out_ready.
  - Saturates at all-ones; no wrap.
  - stat_clr_i=1 loads 0, with priority over increment.
  - Does not count during rst.
- No X propagation: every storage register has a defined reset value.

Decomposition:
- Shared package/header (extend sysconfig.v):
  - OCC_WIDTH=2.
  - Occupancy state encodings OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2.
  - Per-stage payload width macros (IF_ID_W, ID_EX_W, ...).
  - Per-stage BUBBLE constants (instruction field = 32'h00000013).
- One sub-module: ysyx_sat_counter (CNT_W, inc, clr, saturate) for the stall statistic, reused by other performance counters.
- SKID=0 and SKID=1 are generate branches in the same module.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, in_data=0xA5 -> in_ready=0, out_valid=0, out_data=BUBBLE, stall_cnt=0, occupancy=0 throughout; first accept occurs only after rst falls.
- Streaming, both SKID values: push 0x1..0x10 back-to-back with out_ready=1 -> out_data sequence 0x1..0x10 in order, one per cycle after 1-cycle latency, no gaps, stall_cnt stays 0.
- Back-pressure, SKID=1:
  - Stimulus: out_ready=0 from cycle 3, pushing 0x1, 0x2, 0x3.
  - Required: occupancy reaches 2; in_ready is 0 the cycle after the second accept; 0x3 is held upstream.
  - Required: after out_ready returns to 1, order is 0x1, 0x2, 0x3.
  - Required: stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
- Flush while TWO, with a simultaneous accept attempt -> next cycle out_valid=0, out_data=BUBBLE, occupancy=0, in_ready=1; no flushed payload ever appears on out_data.
- Counter saturation: CNT_W=3, hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt stops at 7. Then pulse stat_clr_i together with a stall cycle -> stall_cnt=0.
- Reset mid-operation: occupancy=2, assert rst for 1 cycle -> all outputs return to reset values next cycle; subsequent push of 0x55 emerges as the first output.
